// File: rtl/softmax_ctrl.sv
// Softmax row sequencer: max scan, exp-sum, ln handshake, normalize pass.
// Drives an external exp unit and ln unit; the element buffer reads in 1 cycle.
module softmax_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int EXP_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] xi,
  output logic [DATA_W-1:0] xmax,
  output logic [DATA_W-1:0] lnf,
  output logic              is_stage2,
  output logic              is_stage4,
  input  logic [DATA_W-1:0] exp_out,
  output logic              ln_req,
  output logic [DATA_W-1:0] ln_sum,
  input  logic              ln_ack,
  input  logic [DATA_W-1:0] ln_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    MAX,
    EXP,
    LN,
    NORM,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t state;
  state_t nxt;

  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] addr;
  logic              all_rd;
  logic              rd_vld;
  logic              first;
  logic              rd_phase;
  logic              stage;
  logic              drain;
  logic              exp_vld;
  logic [EXP_LAT:0]  vsr;
  logic [ADDR_W-1:0] asr [EXP_LAT+1];
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] xmax_q;
  logic [DATA_W-1:0] lnf_q;
  logic [DATA_W-1:0] xi_q;
  logic [DATA_W:0]   sum_ext;

  assign stage   = is_stage2 | is_stage4;
  assign rd_en   = rd_phase & ~all_rd;
  assign rd_addr = addr;
  assign exp_vld = vsr[EXP_LAT];
  // Only the top stage may still hold a result: it retires this edge.
  assign drain   = all_rd & ~|vsr[EXP_LAT-1:0];
  assign sum_ext = {1'b0, sum_q} + {1'b0, exp_out};

  assign xi      = (stage & vsr[0]) ? rd_data : xi_q;
  assign xmax    = xmax_q;
  assign lnf     = lnf_q;
  assign ln_sum  = sum_q;
  assign wr_en   = is_stage4 & exp_vld;
  assign wr_data = wr_en ? exp_out : '0;
  assign wr_addr = wr_en ? asr[EXP_LAT] : '0;

  always_comb begin
    nxt       = state;
    rd_phase  = 1'b0;
    is_stage2 = 1'b0;
    is_stage4 = 1'b0;
    ln_req    = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          nxt = (len == '0) ? DONE : MAX;
        end
      end
      MAX: begin
        rd_phase = 1'b1;
        if (all_rd && rd_vld) begin
          nxt = EXP;
        end
      end
      EXP: begin
        rd_phase  = 1'b1;
        is_stage2 = 1'b1;
        if (drain) begin
          nxt = LN;
        end
      end
      LN: begin
        ln_req = 1'b1;
        if (ln_ack) begin
          nxt = NORM;
        end
      end
      NORM: begin
        rd_phase  = 1'b1;
        is_stage4 = 1'b1;
        if (drain) begin
          nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      len_q  <= '0;
      addr   <= '0;
      all_rd <= 1'b0;
      rd_vld <= 1'b0;
      first  <= 1'b0;
      vsr    <= '0;
      sum_q  <= '0;
      xmax_q <= '0;
      lnf_q  <= '0;
      xi_q   <= '0;
      for (int i = 0; i <= EXP_LAT; i++) begin
        asr[i] <= '0;
      end
    end else begin
      state  <= nxt;
      rd_vld <= rd_en;
      vsr    <= {vsr[EXP_LAT-1:0], rd_en & stage};
      asr[0] <= addr;
      for (int i = 1; i <= EXP_LAT; i++) begin
        asr[i] <= asr[i-1];
      end
      // Every read pass restarts the address walk at 0.
      if (state != nxt) begin
        addr   <= '0;
        all_rd <= 1'b0;
      end else if (rd_en) begin
        if (addr == len_q - ONE) begin
          all_rd <= 1'b1;
        end else begin
          addr <= addr + ONE;
        end
      end
      if (state == IDLE && start) begin
        len_q <= len;
        sum_q <= '0;
        first <= 1'b1;
      end
      if (state == MAX && rd_vld) begin
        first <= 1'b0;
        if (first || $signed(rd_data) > $signed(xmax_q)) begin
          xmax_q <= rd_data;
        end
      end
      if (is_stage2 && exp_vld) begin
        sum_q <= sum_ext[DATA_W] ? '1 : sum_ext[DATA_W-1:0];
      end
      if (ln_req && ln_ack) begin
        lnf_q <= ln_result;
      end
      if (stage && vsr[0]) begin
        xi_q <= rd_data;
      end
    end
  end

endmodule

// File: doc/softmax_ctrl.md
SOFTMAX_CTRL -- requirements
Module: softmax_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: width of buffer data, Xmax, Xi, lnF, exp_out and sum.
REQ-002 Parameter ADDR_W, default 8: element-buffer address width.
REQ-003 Parameter EXP_LAT, default 2: cycles from Xi/Xmax/lnF presented to exp_out valid on the exp unit.
REQ-004 Port: clk, input, 1, single clock; all state on rising edge.
REQ-005 Port: rst, input, 1, asynchronous active-low reset.
REQ-006 Port: start, input, 1, one-cycle pulse that begins a softmax row when idle.
REQ-007 Port: len, input, ADDR_W, element count; sampled on accepted start.
REQ-008 Port: rd_en / rd_addr, output, 1 / ADDR_W, buffer read request; 1-cycle read latency.
REQ-009 Port: rd_data, input, DATA_W, signed integer element, valid the cycle after rd_en.
REQ-010 Port: xi / xmax / lnf, output, DATA_W each, operands to the exp unit.
REQ-011 Port: is_stage2 / is_stage4, output, 1 each, exp unit mode selects.
REQ-012 Port: exp_out, input, DATA_W, exp unit result.
REQ-013 Port: ln_req / ln_sum, output, 1 / DATA_W, request to external ln unit with accumulated sum.
REQ-014 Port: ln_ack / ln_result, input, 1 / DATA_W, ln unit completion and fixed-point result (10 fractional bits).
REQ-015 Port: wr_en / wr_addr / wr_data, output, 1 / ADDR_W / DATA_W, normalized result write port.
REQ-016 Port: busy / done, output, 1 each, row in progress / one-cycle completion pulse.

Function
REQ-017 FSM states: IDLE, MAX, EXP, LN, NORM, DONE; transitions only as listed below.
REQ-018 IDLE: start=1 latches len and goes to MAX; if len=0, go directly to DONE with no reads.
REQ-019 MAX/EXP/NORM: issue rd_en=1 with rd_addr 0..len-1 on consecutive cycles, one per cycle, no gaps.
REQ-020 MAX: xmax loaded with first element, then updated with signed greater-than compare each valid rd_data; exit to EXP the cycle after last rd_data consumed.
REQ-021 EXP: xi=rd_data when valid; is_stage2=1 for whole state including drain; xmax held.
REQ-022 EXP: valid shift register of depth 1+EXP_LAT tracks issued reads; each valid exp_out added to sum, unsigned, saturating at all-ones.
REQ-023 EXP exits to LN when all len results retired (shift register empty, all reads issued).
REQ-024 LN: ln_req=1 and ln_sum=sum held until ln_ack=1 sampled; ln_result latched into lnf that cycle; next state NORM; ln_ack outside LN ignored.
REQ-025 NORM: is_stage4=1 for whole state including drain; xi=rd_data; lnf, xmax held.
REQ-026 NORM: each valid exp_out produces wr_en=1, wr_data=exp_out, wr_addr = read address delayed 1+EXP_LAT cycles; exactly len writes, ascending addresses.
REQ-027 NORM exits to DONE after last write; DONE asserts done=1 for one cycle, returns IDLE.
REQ-028 busy=1 in all states except IDLE; start while busy ignored.
REQ-029 is_stage2 and is_stage4 never both 1; both 0 in IDLE, MAX, LN, DONE.
REQ-030 rd_addr and wr_addr never exceed len-1; no wrap at 2^ADDR_W since len is at most 2^ADDR_W-1.

Reset
REQ-031 rst=0 forces IDLE immediately, any cycle, mid-row included; row abandoned, no further reads/writes.
REQ-032 Reset values: rd_en, wr_en, ln_req, is_stage2, is_stage4, busy, done = 0; rd_addr, wr_addr, xi, xmax, lnf, ln_sum, wr_data, sum, valid shift register = 0.
REQ-033 First start accepted on the first rising edge with rst=1.

Verification
REQ-034 len=4, data {3,-7,10,10}, exp model returns 1 per element, ln_ack 3 cycles after ln_req -> xmax=10, ln_sum=4, 4 writes addr 0..3, done pulse once.
REQ-035 len=0 start -> done 1 cycle later, zero rd_en/wr_en/ln_req.
REQ-036 len=1, data {-5} -> xmax=-5 (signed), one EXP read, one write at addr 0.
REQ-037 exp model returns 0xFFFFFFFF, len=3 -> sum saturates, ln_sum=0xFFFFFFFF.
REQ-038 rst=0 during NORM after 2 writes -> next cycle all outputs at reset values; new start runs a full row correctly.
REQ-039 start pulsed during EXP -> ignored; stage flags mutually exclusive every cycle (assertion).
